// File: rtl/NVP_v1_constants.sv
`default_nettype none
// ============================================================================
// Module      : NVP_v1_constants (package)
// Description : Shared constants for the decoded-stream datapath. It holds
//               the default payload field widths, the default stream count
//               and the arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package NVP_v1_constants;

  // Default stream count and payload field widths
  localparam int C_NUMBER_OF_READ_STREAMS  = 3;
  localparam int C_ACTIVATION_BIT_WIDTH    = 8;
  localparam int C_COLUMN_VALUE_BIT_WIDTH  = 9;
  localparam int C_CHANNEL_VALUE_BIT_WIDTH = 10;
  localparam int C_ROW_VALUE_BIT_WIDTH     = 2;

  // Arbiter state encoding
  localparam int ST_W = 2;
  typedef logic [ST_W-1:0] arb_state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_SYNC = 2'd2;

endpackage : NVP_v1_constants
`default_nettype wire

// File: rtl/decoded_stream_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. The search starts at
//               index ptr and wraps modulo N. The first request found is
//               granted as a one-hot vector.
// Ports       : req   - request vector, one bit per stream
//               ptr   - index of the highest-priority stream
//               grant - one-hot grant, all zero when no request is active
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  localparam int            SW  = PTR_W + 1;
  localparam logic [SW-1:0] C_N = SW'(N);

  logic [SW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      // Rotated index (ptr + i) mod N. ptr < N, so one subtraction is enough.
      w_idx = {1'b0, ptr} + SW'(i);
      if (w_idx >= C_N) begin
        w_idx = w_idx - C_N;
      end
      if (!w_found && req[w_idx[PTR_W-1:0]]) begin
        grant[w_idx[PTR_W-1:0]] = 1'b1;
        w_found                 = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/decoded_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : decoded_stream_arbiter
// Description : Merges N decoded activation streams into a single output
//               stream through a one-entry output register.
//               - Barrier mode (conv): a stream that sends its last column
//                 beat is blocked. When every enabled stream has finished the
//                 column, the block spends one SYNC cycle. That cycle pulses
//                 o_column_done and releases all streams.
//               - PW mode: the streams are independent and i_last_column is
//                 only forwarded.
// Ports       : clk, reset (async, active-high)
//               i_start / i_abort         layer control
//               i_barrier_mode, i_stream_enable  configuration, latched on start
//               i_data .. i_relative_row, i_last_column, i_valid / o_ready
//                                         per-stream inputs (packed, stream
//                                         0 in the LSBs)
//               o_data .. o_relative_row, o_stream_id, o_valid / i_ready
//                                         output beat
//               o_column_done, o_column_count, o_busy  status
// Revision    : 1.0 - initial release
// ============================================================================
module decoded_stream_arbiter
  import NVP_v1_constants::*;
#(
  parameter int NUMBER_OF_READ_STREAMS  = C_NUMBER_OF_READ_STREAMS,
  parameter int ACTIVATION_BIT_WIDTH    = C_ACTIVATION_BIT_WIDTH,
  parameter int COLUMN_VALUE_BIT_WIDTH  = C_COLUMN_VALUE_BIT_WIDTH,
  parameter int CHANNEL_VALUE_BIT_WIDTH = C_CHANNEL_VALUE_BIT_WIDTH,
  parameter int ROW_VALUE_BIT_WIDTH     = C_ROW_VALUE_BIT_WIDTH,
  localparam int N     = NUMBER_OF_READ_STREAMS,
  localparam int ACT   = ACTIVATION_BIT_WIDTH,
  localparam int COL   = COLUMN_VALUE_BIT_WIDTH,
  localparam int CH    = CHANNEL_VALUE_BIT_WIDTH,
  localparam int ROW   = ROW_VALUE_BIT_WIDTH,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_barrier_mode,
  input  logic [N-1:0]       i_stream_enable,
  input  logic [N*ACT-1:0]   i_data,
  input  logic [N*COL-1:0]   i_toggled_column,
  input  logic [N*CH-1:0]    i_channel,
  input  logic [N*ROW-1:0]   i_relative_row,
  input  logic [N-1:0]       i_last_column,
  input  logic [N-1:0]       i_valid,
  output logic [N-1:0]       o_ready,
  output logic [ACT-1:0]     o_data,
  output logic [COL-1:0]     o_toggled_column,
  output logic [CH-1:0]      o_channel,
  output logic [ROW-1:0]     o_relative_row,
  output logic [PTR_W-1:0]   o_stream_id,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_column_done,
  output logic [15:0]        o_column_count,
  output logic               o_busy
);

  arb_state_t       r_state;
  logic             r_barrier_mode;
  logic [N-1:0]     r_enable;
  logic [N-1:0]     r_barrier;
  logic [PTR_W-1:0] r_ptr;
  logic [15:0]      r_col_count;
  logic             r_valid;

  logic [N-1:0]     w_req;
  logic [N-1:0]     w_grant;
  logic             w_xfer;
  logic             w_out_free;
  logic             w_all_done;
  logic [PTR_W-1:0] w_gnt_idx;
  logic [PTR_W-1:0] w_ptr_next;
  logic             w_gnt_last;
  logic [ACT-1:0]   w_data;
  logic [COL-1:0]   w_col;
  logic [CH-1:0]    w_ch;
  logic [ROW-1:0]   w_row;

  // The output register can accept a beat when it is empty or being drained.
  assign w_out_free = ~r_valid | i_ready;

  // A stream requests only in RUN, and only while not parked at the barrier.
  // Abort suppresses ready so that no beat is accepted and then dropped.
  assign w_req = r_enable & i_valid & ~r_barrier
               & {N{(r_state == ST_RUN) & w_out_free & ~i_abort}};

  rr_arbiter #(
    .N     (N),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req   (w_req),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  assign o_ready = w_grant;
  assign w_xfer  = |w_grant;

  // One-hot grant to index, plus the payload multiplexer
  always_comb begin
    w_gnt_idx  = '0;
    w_gnt_last = 1'b0;
    w_data     = '0;
    w_col      = '0;
    w_ch       = '0;
    w_row      = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_gnt_idx  = PTR_W'(i);
        w_gnt_last = i_last_column[i];
        w_data     = i_data[i*ACT +: ACT];
        w_col      = i_toggled_column[i*COL +: COL];
        w_ch       = i_channel[i*CH +: CH];
        w_row      = i_relative_row[i*ROW +: ROW];
      end
    end
  end

  assign w_ptr_next = (w_gnt_idx == PTR_W'(N - 1)) ? '0 : w_gnt_idx + 1'b1;

  // Disabled streams count as satisfied. An all-zero mask never syncs.
  assign w_all_done = (r_state == ST_RUN) && r_barrier_mode && (|r_enable)
                    && (&(r_barrier | ~r_enable));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_barrier_mode   <= 1'b0;
      r_enable         <= '0;
      r_barrier        <= '0;
      r_ptr            <= '0;
      r_col_count      <= '0;
      r_valid          <= 1'b0;
      o_data           <= '0;
      o_toggled_column <= '0;
      o_channel        <= '0;
      o_relative_row   <= '0;
      o_stream_id      <= '0;
    end else if (i_abort) begin
      r_state     <= ST_IDLE;
      r_valid     <= 1'b0;
      r_barrier   <= '0;
      r_ptr       <= '0;
      r_col_count <= '0;
    end else begin
      // Single-entry output register
      if (w_xfer) begin
        r_valid          <= 1'b1;
        o_data           <= w_data;
        o_toggled_column <= w_col;
        o_channel        <= w_ch;
        o_relative_row   <= w_row;
        o_stream_id      <= w_gnt_idx;
        r_ptr            <= w_ptr_next;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state        <= ST_RUN;
            r_barrier_mode <= i_barrier_mode;
            r_enable       <= i_stream_enable;
            r_barrier      <= '0;
            r_ptr          <= '0;
            r_col_count    <= '0;
          end
        end
        ST_RUN: begin
          if (w_xfer && r_barrier_mode && w_gnt_last) begin
            r_barrier[w_gnt_idx] <= 1'b1;
          end
          if (w_all_done) begin
            r_state <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          r_barrier   <= '0;
          r_col_count <= r_col_count + 16'd1;
          r_state     <= ST_RUN;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_valid        = r_valid;
  assign o_column_done  = (r_state == ST_SYNC);
  assign o_column_count = r_col_count;
  assign o_busy         = (r_state != ST_IDLE);

endmodule : decoded_stream_arbiter
`default_nettype wire

// File: tb/tb_decoded_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoded_stream_arbiter
// Description : Directed testbench for decoded_stream_arbiter with three
//               streams. The expected grant, status and payload values are
//               worked out by hand for each vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoded_stream_arbiter;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_start, i_abort, i_barrier_mode;
  logic [N-1:0]  i_stream_enable;
  logic [N*8-1:0]  i_data;
  logic [N*9-1:0]  i_toggled_column;
  logic [N*10-1:0] i_channel;
  logic [N*2-1:0]  i_relative_row;
  logic [N-1:0]  i_last_column, i_valid, o_ready;
  logic [7:0]    o_data;
  logic [8:0]    o_toggled_column;
  logic [9:0]    o_channel;
  logic [1:0]    o_relative_row;
  logic [1:0]    o_stream_id;
  logic          o_valid, i_ready, o_column_done, o_busy;
  logic [15:0]   o_column_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] dat [N] = '{8'h5A, 8'h6B, 8'h7C};
  logic [8:0] col [N] = '{9'h0D0, 9'h0E1, 9'h1F2};
  logic [9:0] chn [N] = '{10'h1A0, 10'h2B1, 10'h3C2};
  logic [1:0] row [N] = '{2'd1, 2'd2, 2'd3};

  decoded_stream_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .i_start          (i_start),
    .i_abort          (i_abort),
    .i_barrier_mode   (i_barrier_mode),
    .i_stream_enable  (i_stream_enable),
    .i_data           (i_data),
    .i_toggled_column (i_toggled_column),
    .i_channel        (i_channel),
    .i_relative_row   (i_relative_row),
    .i_last_column    (i_last_column),
    .i_valid          (i_valid),
    .o_ready          (o_ready),
    .o_data           (o_data),
    .o_toggled_column (o_toggled_column),
    .o_channel        (o_channel),
    .o_relative_row   (o_relative_row),
    .o_stream_id      (o_stream_id),
    .o_valid          (o_valid),
    .i_ready          (i_ready),
    .o_column_done    (o_column_done),
    .o_column_count   (o_column_count),
    .o_busy           (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic mode, input logic [N-1:0] en);
    i_start         = 1'b1;
    i_barrier_mode  = mode;
    i_stream_enable = en;
    next();
    i_start = 1'b0;
  endtask

  task automatic do_abort();
    i_abort = 1'b1;
    i_valid = '0;
    next();
    i_abort = 1'b0;
  endtask

  // One cycle: drive valid/last, then check ready, done and count mid-cycle.
  task automatic run_vec(input string tag, input logic [N-1:0] v, input logic [N-1:0] l,
                         input logic [N-1:0] exp_r, input logic exp_d, input logic [15:0] exp_c);
    i_valid       = v;
    i_last_column = l;
    @(negedge clk);
    check({tag, ".ready"}, 32'(o_ready), 32'(exp_r));
    check({tag, ".done"},  32'(o_column_done), 32'(exp_d));
    check({tag, ".count"}, 32'(o_column_count), 32'(exp_c));
    next();
  endtask

  initial begin
    reset = 1'b1;
    i_start = 1'b0; i_abort = 1'b0; i_barrier_mode = 1'b0; i_stream_enable = '0;
    i_last_column = '0; i_valid = '0; i_ready = 1'b1;
    i_data           = {dat[2], dat[1], dat[0]};
    i_toggled_column = {col[2], col[1], col[0]};
    i_channel        = {chn[2], chn[1], chn[0]};
    i_relative_row   = {row[2], row[1], row[0]};
    next();
    @(negedge clk);
    check("rst.valid", 32'(o_valid), 0);
    check("rst.ready", 32'(o_ready), 0);
    check("rst.busy",  32'(o_busy), 0);
    check("rst.done",  32'(o_column_done), 0);
    check("rst.count", 32'(o_column_count), 0);
    check("rst.data",  32'(o_data), 0);
    check("rst.id",    32'(o_stream_id), 0);
    reset = 1'b0;
    next();

    // PW mode round robin. last=1 everywhere must not raise barriers. The
    // live mode/enable inputs are changed after start and must be ignored.
    do_start(1'b0, 3'b111);
    i_barrier_mode = 1'b1; i_stream_enable = 3'b000;
    i_valid = 3'b111; i_last_column = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("pw.ready%0d", k), 32'(o_ready), 32'(1 << (k % 3)));
      check($sformatf("pw.busy%0d", k), 32'(o_busy), 1);
      check($sformatf("pw.done%0d", k), 32'(o_column_done), 0);
      if (k > 0) begin
        check($sformatf("pw.valid%0d", k), 32'(o_valid), 1);
        check($sformatf("pw.id%0d", k), 32'(o_stream_id), 32'((k - 1) % 3));
        check($sformatf("pw.data%0d", k), 32'(o_data), 32'(dat[(k - 1) % 3]));
      end
      next();
    end
    @(negedge clk);
    check("pw.count", 32'(o_column_count), 0);
    do_abort();
    @(negedge clk);
    check("abort.busy",  32'(o_busy), 0);
    check("abort.valid", 32'(o_valid), 0);

    // Barrier mode, all three streams enabled
    do_start(1'b1, 3'b111);
    run_vec("bar1", 3'b001, 3'b001, 3'b001, 1'b0, 16'd0);
    run_vec("bar2", 3'b011, 3'b000, 3'b010, 1'b0, 16'd0);
    run_vec("bar3", 3'b111, 3'b110, 3'b100, 1'b0, 16'd0);
    run_vec("bar4", 3'b111, 3'b110, 3'b010, 1'b0, 16'd0);
    run_vec("bar5", 3'b111, 3'b110, 3'b000, 1'b0, 16'd0);
    run_vec("bar6", 3'b111, 3'b110, 3'b000, 1'b1, 16'd0);
    run_vec("bar7", 3'b111, 3'b000, 3'b100, 1'b0, 16'd1);

    // Backpressure: the held beat stays stable and nothing else is granted.
    run_vec("st0", 3'b000, 3'b000, 3'b000, 1'b0, 16'd1);
    i_ready = 1'b0;
    run_vec("st1", 3'b001, 3'b000, 3'b001, 1'b0, 16'd1);
    for (int k = 0; k < 5; k++) begin
      i_valid = 3'b011;
      @(negedge clk);
      check($sformatf("stall.ready%0d", k), 32'(o_ready), 0);
      check($sformatf("stall.valid%0d", k), 32'(o_valid), 1);
      check($sformatf("stall.data%0d", k), 32'(o_data), 32'(dat[0]));
      check($sformatf("stall.chan%0d", k), 32'(o_channel), 32'(chn[0]));
      check($sformatf("stall.id%0d", k), 32'(o_stream_id), 0);
      next();
    end
    i_ready = 1'b1;
    run_vec("st2", 3'b011, 3'b000, 3'b010, 1'b0, 16'd1);
    i_valid = 3'b000;
    @(negedge clk);
    check("st3.valid", 32'(o_valid), 1);
    check("st3.data",  32'(o_data), 32'(dat[1]));
    check("st3.col",   32'(o_toggled_column), 32'(col[1]));
    check("st3.row",   32'(o_relative_row), 32'(row[1]));
    check("st3.id",    32'(o_stream_id), 1);
    next();
    do_abort();

    // Enable mask 101: stream 1 is never granted.
    do_start(1'b1, 3'b101);
    run_vec("m1", 3'b111, 3'b000, 3'b001, 1'b0, 16'd0);
    run_vec("m2", 3'b111, 3'b000, 3'b100, 1'b0, 16'd0);
    run_vec("m3", 3'b111, 3'b101, 3'b001, 1'b0, 16'd0);
    run_vec("m4", 3'b111, 3'b101, 3'b100, 1'b0, 16'd0);
    run_vec("m5", 3'b111, 3'b000, 3'b000, 1'b0, 16'd0);
    run_vec("m6", 3'b111, 3'b000, 3'b000, 1'b1, 16'd0);
    run_vec("m7", 3'b111, 3'b000, 3'b001, 1'b0, 16'd1);
    do_abort();

    // All-zero mask: stays in RUN with no grant and no sync.
    do_start(1'b1, 3'b000);
    for (int k = 0; k < 3; k++) begin
      run_vec($sformatf("z%0d", k), 3'b111, 3'b111, 3'b000, 1'b0, 16'd0);
    end
    @(negedge clk);
    check("z.busy", 32'(o_busy), 1);
    do_abort();

    // Abort and start together: abort wins, so the block stays idle.
    i_abort = 1'b1; i_start = 1'b1;
    next();
    i_abort = 1'b0; i_start = 1'b0;
    @(negedge clk);
    check("abst.busy", 32'(o_busy), 0);

    // Seven single-stream columns (3 cycles each), then abort while SYNC pends.
    do_start(1'b1, 3'b001);
    for (int t = 0; t < 22; t++) begin
      run_vec($sformatf("c%0d", t), 3'b001, 3'b001,
              (t % 3 == 0) ? 3'b001 : 3'b000, (t % 3 == 2), 16'(t / 3));
    end
    i_abort = 1'b1;
    @(negedge clk);
    check("ab.valid_before", 32'(o_valid), 1);
    check("ab.count_before", 32'(o_column_count), 7);
    check("ab.ready", 32'(o_ready), 0);
    next();
    i_abort = 1'b0; i_valid = '0;
    @(negedge clk);
    check("ab.busy",  32'(o_busy), 0);
    check("ab.valid", 32'(o_valid), 0);
    check("ab.count", 32'(o_column_count), 0);
    check("ab.done",  32'(o_column_done), 0);
    next();

    // Asynchronous reset in the middle of a PW burst
    do_start(1'b0, 3'b111);
    i_valid = 3'b111; i_last_column = 3'b000;
    next();
    next();
    #2 reset = 1'b1;
    #1;
    check("ar.valid", 32'(o_valid), 0);
    check("ar.ready", 32'(o_ready), 0);
    check("ar.busy",  32'(o_busy), 0);
    check("ar.data",  32'(o_data), 0);
    check("ar.chan",  32'(o_channel), 0);
    check("ar.id",    32'(o_stream_id), 0);
    next();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("post.ready%0d", k), 32'(o_ready), 0);
      check($sformatf("post.valid%0d", k), 32'(o_valid), 0);
      next();
    end
    do_start(1'b0, 3'b111);
    @(negedge clk);
    check("restart.ready", 32'(o_ready), 32'(3'b001));
    next();
    @(negedge clk);
    check("restart.valid", 32'(o_valid), 1);
    check("restart.data",  32'(o_data), 32'(dat[0]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_decoded_stream_arbiter
`default_nettype wire
